// File: rtl/pipe_types.sv
// Shared types for the elastic pipeline stage: occupancy states and default counter width.
package pipe_types;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid storage for pipe_stage_reg: main entry drives the output, skid entry
// absorbs one beat of back-pressure so in_ready can come straight from a flop.
module pipe_skid_buf
    import pipe_types::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    stage_state_e     state_q, state_n;
    logic [WIDTH-1:0] main_q, main_n;
    logic [WIDTH-1:0] skid_q, skid_n;
    logic             accept, emit;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_n;
            main_q  <= main_n;
            skid_q  <= skid_n;
        end
    end

    always_comb begin
        state_n = state_q;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = BUBBLE;
            skid_n  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_n = ONE;
                        main_n  = in_data;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_n = in_data;
                    end else if (accept) begin
                        state_n = TWO;
                        skid_n  = in_data;
                    end else if (emit) begin
                        state_n = EMPTY;
                        main_n  = BUBBLE;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the skid-to-main shift can happen
                    if (emit) begin
                        state_n = ONE;
                        main_n  = skid_q;
                        skid_n  = BUBBLE;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    main_n  = BUBBLE;
                    skid_n  = BUBBLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry variant with a registered in_ready.
module pipe_stage_reg
    import pipe_types::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

`ifdef PIPE_STAGE_SKID_EN
    pipe_skid_buf #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );
`else
    logic             vld_q;
    logic [WIDTH-1:0] data_q;

    // Single entry: a draining entry can be refilled on the same edge.
    assign in_ready  = !vld_q || out_ready;
    assign out_valid = vld_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= BUBBLE;
        end else if (flush) begin
            vld_q  <= 1'b0;
            data_q <= BUBBLE;
        end else if (in_valid && in_ready) begin
            vld_q  <= 1'b1;
            data_q <= in_data;
        end else if (vld_q && out_ready) begin
            vld_q  <= 1'b0;
            data_q <= BUBBLE;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register, the successor to the fixed-width load/reset stage registers between pipeline stages. It carries one WIDTH-bit payload, typically a packed control word plus operands. Transfers use a valid/ready handshake instead of a global load, so each stage can stall independently. Flush squashes any held entry to a bubble value, and an on-block counter records back-pressure cycles.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- BUBBLE, '0, WIDTH-bit value driven on out_data whenever no valid entry is presented
- CNT_W, 16, width of stall counter (≥1)
- clk  input  1  sole clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- flush  input  1  synchronous squash of all held entries and the current input
- in_valid  input  1  upstream presents in_data
- in_ready  output  1  stage accepts in_data this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  stage presents out_data
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  payload, or BUBBLE when out_valid=0
- stall_cnt  output  CNT_W  saturating count of back-pressured cycles

## Operation
- Accept occurs when in_valid && in_ready at a rising edge. Emit occurs when out_valid && out_ready at a rising edge.
- Payload is never modified and entries stay in FIFO order. No entry is duplicated or lost except by flush.
- flush has priority over accept and emit. At the edge it clears all entries. in_data on that edge is discarded even if in_valid=1. in_ready is not forced low by flush.
- stall_cnt increments on every edge with out_valid && !out_ready && !flush. It holds at all-ones (saturates). Only rst clears it.
- out_data equals BUBBLE whenever out_valid=0. This applies after reset, after flush, and after the last entry drains.

## Timing
- Reset (async assert, released synchronously to clk by the system) sets: out_valid=0, out_data=BUBBLE, stall_cnt=0. in_ready=1 in both modes.
- Latency is 1 cycle: data accepted at edge N appears on out_data after edge N when the stage was empty.
- Throughput is 1 transfer/cycle when out_ready stays high.
- Base mode (macro undefined), single entry:
  - in_ready = !out_valid || out_ready, a combinational path from out_ready.
  - Accept with simultaneous emit replaces the entry (valid stays 1).
  - Emit without accept sets valid=0 and loads BUBBLE.
- rst asserted mid-transfer clears immediately, without waiting for clk. The handshake in flight is lost.

## Configuration
- PIPE_STAGE_SKID_EN defined: adds a second (skid) entry, and in_ready becomes a registered output.
  - in_ready = !skid_valid.
  - FSM states: EMPTY → ONE on accept. ONE → TWO on accept without emit. ONE → EMPTY on emit without accept. TWO → ONE on emit; the skid entry moves to main the same edge.
  - ONE stays in ONE on simultaneous accept+emit.
  - In TWO, in_ready=0, so accept is impossible.
  - flush returns to EMPTY from any state.
- Undefined: base single-entry behaviour above. There is no skid storage and no FSM register beyond the valid bit.
- Cycle timing of out_* is identical in both modes. Only in_ready timing and capacity (1 vs 2) differ.

## Structure
- Shared package pipe_types holds the stage state enum (EMPTY, ONE, TWO) and the default CNT_W constant.
- One natural sub-module, pipe_skid_buf: the 2-entry storage and FSM. Instantiate it only under PIPE_STAGE_SKID_EN.
- Existing stage registers (e.g. the ID/EX boundary) re-instantiate this block with WIDTH = packed struct width.

## Test plan
- Reset: rst=1 mid-cycle with WIDTH=32, BUBBLE=32'h00000013 → immediately out_valid=0, out_data=32'h13, stall_cnt=0, in_ready=1.
- Streaming: in_valid=1 with data 1,2,3,4 on consecutive edges, out_ready=1 → out_data 1,2,3,4 one edge later, no gaps, stall_cnt=0.
- Back-pressure (skid): accept A, then out_ready=0 with B offered → B held, in_ready=0 next cycle. After 3 stalled edges stall_cnt=3. out_ready=1 → A then B emitted, then state EMPTY.
- Flush: hold A (and B in skid), assert flush with in_valid=1, data C → next cycle out_valid=0, out_data=BUBBLE, C never emitted, stall_cnt unchanged on that edge.
- Saturation: CNT_W=4, out_ready=0 for 20 stalled cycles → stall_cnt=4'hF, holding.
- Base mode (macro undefined): out_valid=1, out_ready=1, in_valid=1 on the same edge → in_ready=1 combinationally, entry replaced, out_valid stays 1.
